photodiode_scan_ctrl: RTL and testbench

PHOTODIODE_SCAN_CTRL -- requirements
Module: photodiode_scan_ctrl

---
 rtl/photodiode_pkg.sv | 12 +
 rtl/pd_chan_accum.sv | 55 +++++
 rtl/photodiode_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_photodiode_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/photodiode_pkg.sv
// Shared state encoding and default sizing for the photodiode scan controller.
package photodiode_pkg;
  localparam int NCH_DEF        = 5;
  localparam int TBITS_DEF      = 12;
  localparam int SHOTS_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOT   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;
endpackage

// File: rtl/pd_chan_accum.sv
// One photodiode channel: first-edge capture per shot and delay accumulation.
module pd_chan_accum
  import photodiode_pkg::*;
#(
  parameter int TBITS      = TBITS_DEF,
  parameter int SHOTS_LOG2 = SHOTS_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_rise,
  input  logic             i_shot_end,
  input  logic [TBITS-1:0] i_timer,
  output logic [TBITS-1:0] o_delay,
  output logic             o_miss
);
  localparam int ABITS = TBITS + SHOTS_LOG2;

  logic             r_hit;
  logic             r_miss;
  logic [TBITS-1:0] r_cap;
  logic [ABITS-1:0] r_acc;
  logic             w_hit_now;
  logic [TBITS-1:0] w_val;

  assign w_hit_now = i_en & i_rise & ~r_hit;
  // At shot end the timer equals period-1, which is both the miss value and
  // the value of an edge landing on the last cycle.
  assign w_val = r_hit ? r_cap : i_timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      r_cap  <= '0;
      r_acc  <= '0;
    end else if (i_clear) begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      r_cap  <= '0;
      r_acc  <= '0;
    end else if (i_shot_end) begin
      r_acc <= r_acc + ABITS'(w_val);
      r_hit <= 1'b0;
      if (!r_hit && !w_hit_now) r_miss <= 1'b1;
    end else if (w_hit_now) begin
      r_hit <= 1'b1;
      r_cap <= i_timer;
    end
  end

  assign o_delay = r_acc[ABITS-1:SHOTS_LOG2];
  assign o_miss  = r_miss;
endmodule

// File: rtl/photodiode_scan_ctrl.sv
// Photodiode scan sequencer: fires LED shots, averages per-channel edge delays,
// then streams one result per channel over a valid/ready handshake.
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_SHOT   | timer running, LED pulsed, channels capturing edges
//   ST_REPORT | presenting channel results in order
module photodiode_scan_ctrl
  import photodiode_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int TBITS      = TBITS_DEF,
  parameter int SHOTS_LOG2 = SHOTS_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   PD,
  input  logic             start,
  input  logic             abort,
  input  logic [TBITS-1:0] cfg_period,
  input  logic [TBITS-1:0] cfg_pulse,
  output logic             led_drive,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       res_chan,
  output logic [TBITS-1:0] res_delay,
  output logic             res_miss
);
  state_t                r_state, w_state_nxt;
  logic [TBITS-1:0]      r_timer, r_period_m1, r_pulse;
  logic [SHOTS_LOG2-1:0] r_shot;
  logic [2:0]            r_chan;
  logic                  r_led, w_led_nxt, w_clear;
  logic [NCH-1:0]        r_pd_s1, r_pd_s2, r_pd_d, w_rise;
  logic [TBITS-1:0]      w_period_eff, w_pulse_eff;
  logic                  w_shot_end, w_last_shot, w_last_chan, w_in_shot, w_in_rpt;
  logic [TBITS-1:0]      w_delay [NCH];
  logic [NCH-1:0]        w_miss;
  logic [TBITS-1:0]      w_sel_delay;
  logic                  w_sel_miss;

  assign w_period_eff = (cfg_period < TBITS'(2)) ? TBITS'(2) : cfg_period;
  assign w_pulse_eff  = (cfg_pulse == '0) ? TBITS'(1) :
                        (cfg_pulse >= w_period_eff) ? (w_period_eff - TBITS'(1)) : cfg_pulse;

  assign w_in_shot   = (r_state == ST_SHOT);
  assign w_in_rpt    = (r_state == ST_REPORT);
  assign w_shot_end  = w_in_shot && (r_timer == r_period_m1);
  assign w_last_shot = (r_shot == '1);
  assign w_last_chan = (r_chan == 3'(NCH - 1));
  assign w_rise      = r_pd_s2 & ~r_pd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_led_nxt   = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          w_state_nxt = ST_SHOT;
          w_clear     = 1'b1;
          w_led_nxt   = 1'b1;
        end
        ST_SHOT: if (w_shot_end) begin
          if (w_last_shot) w_state_nxt = ST_REPORT;
          else             w_led_nxt   = 1'b1;
        end else begin
          w_led_nxt = (r_timer + TBITS'(1)) < r_pulse;
        end
        ST_REPORT: if (res_ready && w_last_chan) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer     <= '0;
      r_shot      <= '0;
      r_period_m1 <= '0;
      r_pulse     <= '0;
    end else if (w_clear) begin
      r_timer     <= '0;
      r_shot      <= '0;
      r_period_m1 <= w_period_eff - TBITS'(1);
      r_pulse     <= w_pulse_eff;
    end else if (w_in_shot) begin
      if (w_shot_end) begin
        r_timer <= '0;
        r_shot  <= r_shot + SHOTS_LOG2'(1);
      end else begin
        r_timer <= r_timer + TBITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pd_s1 <= '0;
      r_pd_s2 <= '0;
      r_pd_d  <= '0;
      r_chan  <= '0;
    end else begin
      r_pd_s1 <= PD;
      r_pd_s2 <= r_pd_s1;
      r_pd_d  <= r_pd_s2;
      if (!w_in_rpt)      r_chan <= '0;
      else if (res_ready) r_chan <= w_last_chan ? 3'd0 : (r_chan + 3'd1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pd_chan_accum #(
      .TBITS      (TBITS),
      .SHOTS_LOG2 (SHOTS_LOG2)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_clear),
      .i_en       (w_in_shot),
      .i_rise     (w_rise[g]),
      .i_shot_end (w_shot_end),
      .i_timer    (r_timer),
      .o_delay    (w_delay[g]),
      .o_miss     (w_miss[g])
    );
  end

  always_comb begin
    w_sel_delay = '0;
    w_sel_miss  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_chan == 3'(i)) begin
        w_sel_delay = w_delay[i];
        w_sel_miss  = w_miss[i];
      end
    end
  end

  assign led_drive = r_led;
  assign busy      = (r_state != ST_IDLE);
  assign res_valid = w_in_rpt;
  assign res_chan  = w_in_rpt ? r_chan : 3'd0;
  assign res_delay = w_in_rpt ? w_sel_delay : '0;
  assign res_miss  = w_in_rpt & w_sel_miss;
endmodule

// File: tb/tb_photodiode_scan_ctrl.sv
// Randomized bench for photodiode_scan_ctrl with a per-cycle PD history and an
// edge/average reference model derived from the shot timing rules.
module tb_photodiode_scan_ctrl;
  localparam int NCH   = 5;
  localparam int TBITS = 12;
  localparam int NSHOT = 16;
  localparam int HSZ   = 16384;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   PD;
  logic             start, abort, res_ready;
  logic [TBITS-1:0] cfg_period, cfg_pulse;
  logic             led_drive, busy, res_valid, res_miss;
  logic [2:0]       res_chan;
  logic [TBITS-1:0] res_delay;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [NCH-1:0] hist [HSZ];
  int   exp_d [NCH];
  logic exp_m [NCH];
  int   obs_d [NCH];
  logic obs_m [NCH];

  photodiode_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .PD         (PD),
    .start      (start),
    .abort      (abort),
    .cfg_period (cfg_period),
    .cfg_pulse  (cfg_pulse),
    .led_drive  (led_drive),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_chan   (res_chan),
    .res_delay  (res_delay),
    .res_miss   (res_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    hist[cyc % HSZ] = PD;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [NCH-1:0] hv(input int c);
    if (c < 0) return '0;
    return hist[c % HSZ];
  endfunction

  task automatic drive_pd(input int t, input logic fixed, input logic [NCH-1:0] dead);
    logic [NCH-1:0] v;
    v = PD;
    for (int i = 0; i < NCH; i++)
      if ($urandom_range(5) == 0) v[i] = ~v[i];
    v = v & ~dead;
    if (fixed) v[0] = (t >= 23 && t < 60);
    PD = v;
  endtask

  // Sync output in cycle c is PD from cycle c-2; its delayed copy is from c-3.
  function automatic void ref_model(input int s, input int per);
    int acc, v, c;
    logic m, hit;
    logic [NCH-1:0] a, b;
    for (int ch = 0; ch < NCH; ch++) begin
      acc = 0;
      m   = 1'b0;
      for (int k = 0; k < NSHOT; k++) begin
        v   = per - 1;
        hit = 1'b0;
        for (int t = 0; t < per; t++) begin
          c = s + 1 + k * per + t;
          a = hv(c - 2);
          b = hv(c - 3);
          if (!hit && a[ch] && !b[ch]) begin
            hit = 1'b1;
            v   = t;
          end
        end
        if (!hit) m = 1'b1;
        acc += v;
      end
      exp_d[ch] = acc / NSHOT;
      exp_m[ch] = m;
    end
  endfunction

  // rdy_mode: 0..100 = percent ready, negative = stall 7 cycles on channel 2
  task automatic run_meas(input int per, input int pul, input int rdy_mode,
                          input logic [NCH-1:0] dead, input logic fixed,
                          input int abort_at, input logic rst_rpt);
    int per_e, pul_e, s, nshot, ech, stall, guard;
    logic rdy;
    per_e = (per < 2) ? 2 : per;
    pul_e = (pul < 1) ? 1 : ((pul >= per_e) ? per_e - 1 : pul);
    cfg_period = TBITS'(per);
    cfg_pulse  = TBITS'(pul);
    start = 1'b1;
    s = cyc;
    drive_pd(-1, fixed, dead);
    tick();
    start = 1'b0;
    cfg_period = TBITS'($urandom);
    cfg_pulse  = TBITS'($urandom);
    nshot = NSHOT * per_e;
    for (int k = 1; k <= nshot; k++) begin
      chk("busy_shot", busy, 1);
      chk("led_shot", led_drive, ((k - 1) % per_e) < pul_e);
      chk("valid_shot", res_valid, 0);
      start = ($urandom_range(15) == 0);
      if (k == abort_at) begin
        abort = 1'b1;
        drive_pd(-1, fixed, dead);
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_led", led_drive, 0);
        chk("abort_valid", res_valid, 0);
        repeat (3) begin
          drive_pd(-1, fixed, dead);
          tick();
          chk("abort_idle_valid", res_valid, 0);
          chk("abort_idle_busy", busy, 0);
        end
        return;
      end
      drive_pd((k - 1) % per_e, fixed, dead);
      tick();
    end
    start = 1'b0;
    ref_model(s, per_e);
    if (rst_rpt) begin
      chk("valid_pre_rst", res_valid, 1);
      #2 rst = 1'b1;
      start = 1'b1;
      #1;
      chk("rst_led", led_drive, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_chan", res_chan, 0);
      chk("rst_delay", res_delay, 0);
      chk("rst_miss", res_miss, 0);
      PD = '0;
      repeat (3) begin
        tick();
        chk("busy_in_rst", busy, 0);
        chk("valid_in_rst", res_valid, 0);
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (3) begin
        tick();
        chk("busy_after_rst", busy, 0);
      end
      return;
    end
    ech   = 0;
    stall = 0;
    guard = 0;
    while (ech < NCH && guard < 500) begin
      chk("rpt_valid", res_valid, 1);
      chk("rpt_busy", busy, 1);
      chk("rpt_led", led_drive, 0);
      chk("rpt_chan", res_chan, ech);
      chk("rpt_delay", res_delay, exp_d[ech]);
      chk("rpt_miss", res_miss, exp_m[ech]);
      obs_d[ech] = int'(res_delay);
      obs_m[ech] = res_miss;
      if (rdy_mode < 0) begin
        rdy = !(ech == 2 && stall < 7);
        if (!rdy) stall++;
      end else begin
        rdy = ($urandom_range(99) < rdy_mode);
      end
      res_ready = rdy;
      start = ($urandom_range(7) == 0);
      drive_pd(-1, fixed, dead);
      tick();
      if (rdy) ech++;
      guard++;
    end
    res_ready = 1'b0;
    start     = 1'b0;
    chk("rpt_count", ech, NCH);
    chk("done_busy", busy, 0);
    chk("done_valid", res_valid, 0);
    if (rdy_mode < 0) chk("stall_cycles", stall, 7);
  endtask

  initial begin
    int per, pul;
    logic [NCH-1:0] dead;
    for (int i = 0; i < HSZ; i++) hist[i] = '0;
    rst = 1'b1; PD = '0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cfg_period = '0; cfg_pulse = '0;
    #1;
    chk("reset_led", led_drive, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_chan", res_chan, 0);
    chk("reset_delay", res_delay, 0);
    chk("reset_miss", res_miss, 0);
    start = 1'b1;
    repeat (3) begin
      tick();
      chk("busy_held_rst", busy, 0);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (3) tick();

    cfg_period = TBITS'(10);
    cfg_pulse  = TBITS'(3);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_prio_busy", busy, 0);
    chk("abort_prio_led", led_drive, 0);

    run_meas(100, 10, 100, 5'b10000, 1'b1, -1, 1'b0);
    chk("fixed_ch0_delay", obs_d[0], 25);
    chk("fixed_ch0_miss", obs_m[0], 0);
    chk("dead_ch4_delay", obs_d[4], 99);
    chk("dead_ch4_miss", obs_m[4], 1);

    run_meas(20, 5, -1, '0, 1'b0, -1, 1'b0);
    run_meas(30, 12, 80, '0, 1'b0, 5 * 30 + 4, 1'b0);
    run_meas(30, 12, 80, '0, 1'b0, -1, 1'b0);
    run_meas(1, 0, 100, '0, 1'b0, -1, 1'b0);
    run_meas(7, 50, 60, '0, 1'b0, -1, 1'b0);
    for (int n = 0; n < 5; n++) begin
      per  = $urandom_range(40, 2);
      pul  = $urandom_range(per + 3, 0);
      dead = NCH'($urandom) & NCH'($urandom);
      run_meas(per, pul, 50, dead, 1'b0, -1, 1'b0);
    end
    run_meas(3, 1, 100, '0, 1'b0, -1, 1'b1);
    run_meas(9, 4, 70, '0, 1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
